// File: rtl/eth_tx_hdr_inserter.sv
// eth_tx_hdr_inserter: prepends a 14-byte Ethernet L2 header (dst MAC, src MAC, EtherType) to a 64-bit AXI-Stream payload
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   en_i                                allows a new frame to start (sampled only in IDLE)
//   dst_mac_i, src_mac_i, ethertype_i   header fields, MSB byte sent first, latched at frame start
//   in_t*_i, in_tready_o                payload stream
//   out_t*_o, out_tready_i              framed stream (tstrb mirrors tkeep, tid/tdest tied 0)
//   busy_o                              high while a frame is in progress
//   frame_cnt_o                         wrapping count of completed frames
module eth_tx_hdr_inserter #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned UserWidth = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [47:0]            dst_mac_i,
  input  logic [47:0]            src_mac_i,
  input  logic [15:0]            ethertype_i,
  input  logic [DataWidth-1:0]   in_tdata_i,
  input  logic [DataWidth/8-1:0] in_tkeep_i,
  input  logic                   in_tlast_i,
  input  logic [UserWidth-1:0]   in_tuser_i,
  input  logic                   in_tvalid_i,
  output logic                   in_tready_o,
  output logic [DataWidth-1:0]   out_tdata_o,
  output logic [DataWidth/8-1:0] out_tstrb_o,
  output logic [DataWidth/8-1:0] out_tkeep_o,
  output logic                   out_tlast_o,
  output logic                   out_tid_o,
  output logic                   out_tdest_o,
  output logic [UserWidth-1:0]   out_tuser_o,
  output logic                   out_tvalid_o,
  input  logic                   out_tready_i,
  output logic                   busy_o,
  output logic [15:0]            frame_cnt_o
);
  if (DataWidth != 64) begin : g_width_check
    $error("eth_tx_hdr_inserter: DataWidth must be 64");
  end
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, STREAM, FLUSH} state_e;
  state_e               state_q, state_d;
  logic [111:0]         hdr_q, hdr_d;
  logic [47:0]          carry_q, carry_d;
  logic [5:0]           ckeep_q, ckeep_d;
  logic [UserWidth-1:0] cuser_q, cuser_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [63:0]          hdr0_w;
  logic [47:0]          hdr1_w;
  logic                 pass, hs_in, short_last;
  // hdr_q holds {dst, src, type}; its MSB byte goes out first, so beats are byte-reversed into lanes
  always_comb begin
    hdr0_w = '0;
    hdr1_w = '0;
    for (int i = 0; i < 8; i++) hdr0_w[8*i +: 8] = hdr_q[111-8*i -: 8];
    for (int i = 0; i < 6; i++) hdr1_w[8*i +: 8] = hdr_q[47-8*i -: 8];
  end
  // HDR1/STREAM pass the input handshake straight through; a last beat with at most
  // two bytes (lane 2 empty) fits entirely after the six carried/header lanes
  always_comb begin
    pass         = state_q == HDR1 || state_q == STREAM;
    short_last   = in_tlast_i && !in_tkeep_i[2];
    hs_in        = pass && in_tvalid_i && out_tready_i;
    in_tready_o  = pass && out_tready_i;
    out_tvalid_o = pass ? in_tvalid_i : (state_q == HDR0 || state_q == FLUSH);
    out_tdata_o  = state_q == HDR0   ? hdr0_w :
                   state_q == HDR1   ? {in_tdata_i[15:0], hdr1_w} :
                   state_q == STREAM ? {in_tdata_i[15:0], carry_q} :
                   state_q == FLUSH  ? {16'h0, carry_q} : '0;
    out_tkeep_o  = state_q == HDR0  ? 8'hFF :
                   pass             ? (short_last ? {in_tkeep_i[1:0], 6'h3F} : 8'hFF) :
                   state_q == FLUSH ? {2'b00, ckeep_q} : 8'h00;
    out_tlast_o  = pass ? short_last : state_q == FLUSH;
    out_tuser_o  = pass ? in_tuser_i : state_q == FLUSH ? cuser_q : '0;
    out_tstrb_o  = out_tkeep_o;
    out_tid_o    = 1'b0;
    out_tdest_o  = 1'b0;
    busy_o       = state_q != IDLE;
    frame_cnt_o  = cnt_q;
  end
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    carry_d = carry_q;
    ckeep_d = ckeep_q;
    cuser_d = cuser_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && en_i && in_tvalid_i) begin
      hdr_d   = {dst_mac_i, src_mac_i, ethertype_i};
      state_d = HDR0;
    end
    if (state_q == HDR0 && out_tready_i) state_d = HDR1;
    if (hs_in) begin
      carry_d = in_tdata_i[63:16];
      cuser_d = in_tuser_i;
      ckeep_d = in_tkeep_i[7:2];
      state_d = !in_tlast_i ? STREAM : short_last ? IDLE : FLUSH;
    end
    if (state_q == FLUSH && out_tready_i) state_d = IDLE;
    cnt_d = ((hs_in && short_last) || (state_q == FLUSH && out_tready_i)) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      carry_q <= '0;
      ckeep_q <= '0;
      cuser_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      carry_q <= carry_d;
      ckeep_q <= ckeep_d;
      cuser_q <= cuser_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_eth_tx_hdr_inserter.sv
// tb_eth_tx_hdr_inserter: directed bench with a byte-queue frame model and a per-cycle output checker
module tb_eth_tx_hdr_inserter;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [47:0] dst, src;
  logic [15:0] etype;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tlast = 1'b0, in_tvalid = 1'b0;
  logic [0:0]  in_tuser = '0;
  logic        in_tready, out_tlast, out_tid, out_tdest, out_tvalid, busy;
  logic        out_tready = 1'b1;
  logic [63:0] out_tdata;
  logic [7:0]  out_tstrb, out_tkeep;
  logic [0:0]  out_tuser;
  logic [15:0] frame_cnt;
  int          errors = 0, checks = 0, ecnt = 0;
  bit          model_on = 1'b1, bp = 1'b0;

  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;
  beat_t exp_q[$], obs[$];

  eth_tx_hdr_inserter dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .dst_mac_i(dst), .src_mac_i(src), .ethertype_i(etype),
    .in_tdata_i(in_tdata), .in_tkeep_i(in_tkeep), .in_tlast_i(in_tlast),
    .in_tuser_i(in_tuser), .in_tvalid_i(in_tvalid), .in_tready_o(in_tready),
    .out_tdata_o(out_tdata), .out_tstrb_o(out_tstrb), .out_tkeep_o(out_tkeep),
    .out_tlast_o(out_tlast), .out_tid_o(out_tid), .out_tdest_o(out_tdest),
    .out_tuser_o(out_tuser), .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
    .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the whole frame is just header bytes followed by payload bytes, cut into 8-byte beats
  task automatic expect_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input byte unsigned pl[$]);
    byte unsigned b[$];
    for (int i = 0; i < 6; i++) b.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(s[47-8*i -: 8]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    foreach (pl[i]) b.push_back(pl[i]);
    for (int i = 0; i < b.size(); i += 8) begin
      beat_t e;
      e.d = '0;
      e.k = '0;
      e.u = 1'b0;
      for (int j = 0; j < 8 && i + j < b.size(); j++) begin
        e.d[8*j +: 8] = b[i+j];
        e.k[j] = 1'b1;
      end
      e.l = (i + 8 >= b.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input byte unsigned pl[$], input bit gaps);
    int n = (pl.size() + 7) / 8;
    for (int bi = 0; bi < n; bi++) begin
      int rem = pl.size() - 8 * bi;
      int waited = 0;
      bit hs = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_tdata = '0;
      for (int j = 0; j < 8 && j < rem; j++) in_tdata[8*j +: 8] = pl[8*bi+j];
      in_tkeep = rem >= 8 ? 8'hFF : 8'((1 << rem) - 1);
      in_tlast = (bi == n - 1);
      in_tuser = 1'($urandom_range(0, 1));
      in_tvalid = 1'b1;
      while (!hs && waited < 200) begin
        @(negedge clk);
        hs = in_tready;
        @(posedge clk);
        #1;
        waited++;
      end
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL in_handshake: beat %0d not accepted after %0d cycles", bi, waited);
      end
      if (bi == 0) dst = dst + 48'd1;
      in_tvalid = 1'b0;
    end
  endtask

  task automatic frame_pl(input byte unsigned pl[$], input bit gaps);
    expect_frame(dst, src, etype, pl);
    send(pl, gaps);
    ecnt++;
  endtask

  task automatic frame(input int len, input bit gaps);
    byte unsigned pl[$];
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    frame_pl(pl, gaps);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_remaining_beats", exp_q.size(), 0);
    @(negedge clk);
    check("frame_cnt", frame_cnt, ecnt[15:0]);
    @(posedge clk);
    #1;
  endtask

  // Compare process: every output handshake is matched against the model, and stalls must hold
  logic [63:0] pd;
  logic [7:0]  pk;
  logic        plast, pstall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !model_on) pstall = 1'b0;
    else begin
      if (pstall) begin
        check("stall_valid", out_tvalid, 1);
        check("stall_data", out_tdata, pd);
        check("stall_keep", out_tkeep, pk);
        check("stall_last", out_tlast, plast);
      end
      if (in_tready) check("in_ready_gating", {busy, out_tready}, 2'b11);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %h keep %h with nothing expected", out_tdata, out_tkeep);
        end else begin
          beat_t e;
          logic [63:0] m;
          e = exp_q.pop_front();
          for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{e.k[j]}};
          check("out_data", out_tdata & m, e.d);
          check("out_keep", out_tkeep, e.k);
          check("out_strb", out_tstrb, e.k);
          check("out_last", out_tlast, e.l);
          check("out_id_dest", {out_tid, out_tdest}, 0);
          obs.push_back('{out_tdata, out_tkeep, out_tlast, out_tuser[0]});
        end
      end
      pstall = out_tvalid && !out_tready;
      pd = out_tdata;
      pk = out_tkeep;
      plast = out_tlast;
    end
  end

  int lens[8] = '{3, 7, 9, 13, 14, 15, 16, 21};

  initial begin
    byte unsigned pl[$];
    int bad;
    dst = 48'h020000000001;
    src = 48'h020000000002;
    etype = 16'h0800;
    @(negedge clk);
    check("rst_out_valid", out_tvalid, 0);
    check("rst_in_ready", in_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;

    // single-beat frame with hand-computed beats
    pl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    obs.delete();
    frame_pl(pl, 1'b0);
    drain();
    check("t1_beats", obs.size(), 3);
    check("t1_cnt", frame_cnt, 1);
    if (obs.size() == 3) begin
      check("t1_b0_data", obs[0].d, 64'h0002010000000002);
      check("t1_b0_keep", obs[0].k, 8'hFF);
      check("t1_b1_data", obs[1].d, 64'h0100000802000000);
      check("t1_b1_keep", obs[1].k, 8'hFF);
      check("t1_b2_data", obs[2].d & 64'h0000FFFFFFFFFFFF, 64'h0000070605040302);
      check("t1_b2_keep", obs[2].k, 8'h3F);
      check("t1_b2_last", obs[2].l, 1);
    end

    // 1-byte and 2-byte payloads end in the header-tail beat
    pl = '{8'hAB};
    obs.delete();
    frame_pl(pl, 1'b0);
    drain();
    check("t2_beats", obs.size(), 2);
    if (obs.size() == 2) begin
      check("t2_keep", obs[1].k, 8'h7F);
      check("t2_last", obs[1].l, 1);
      check("t2_lane6", obs[1].d[55:48], 8'hAB);
    end
    pl = '{8'hC1, 8'hC2};
    obs.delete();
    frame_pl(pl, 1'b0);
    drain();
    check("t3_beats", obs.size(), 2);
    if (obs.size() == 2) begin
      check("t3_keep", obs[1].k, 8'hFF);
      check("t3_last", obs[1].l, 1);
      check("t3_lanes67", obs[1].d[63:48], 16'hC2C1);
    end

    // 64-byte payload under random back-pressure and input gaps
    bp = 1'b1;
    obs.delete();
    frame(64, 1'b1);
    drain();
    check("t4_beats", obs.size(), 10);
    if (obs.size() == 10) check("t4_last_keep", obs[9].k, 8'h3F);

    // assorted lengths, back-to-back, alternating back-pressure
    foreach (lens[i]) begin
      bp = i[0];
      frame(lens[i], i[0]);
    end
    drain();
    bp = 1'b0;

    // enable gating
    en = 1'b0;
    in_tdata = 64'h1122334455667788;
    in_tkeep = 8'hFF;
    in_tlast = 1'b1;
    in_tvalid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_tready || out_tvalid || busy) bad++;
    end
    check("en_gate_idle", bad, 0);
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    en = 1'b1;
    fork
      frame(30, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
      end
    join
    drain();
    fork
      frame(5, 1'b0);
      begin
        int b2 = 0;
        repeat (10) begin
          @(negedge clk);
          if (busy || out_tvalid || in_tready) b2++;
        end
        check("en_hold_next", b2, 0);
        @(posedge clk);
        #1;
        en = 1'b1;
      end
    join
    drain();

    // reset in the middle of STREAM
    model_on = 1'b0;
    in_tdata = 64'hDEADBEEFCAFEF00D;
    in_tkeep = 8'hFF;
    in_tlast = 1'b0;
    in_tvalid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_tvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cnt", frame_cnt, 0);
    in_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    ecnt = 0;
    model_on = 1'b1;
    frame(20, 1'b0);
    drain();

    // counter wrap
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    @(negedge clk);
    check("wrap_pre", frame_cnt, 16'hFFFF);
    @(posedge clk);
    #1;
    ecnt = 16'hFFFF;
    frame(3, 1'b0);
    drain();
    check("wrap_zero", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
